id_exe_pipe_slot: RTL

//  Parametrised ID->EXE pipeline boundary with valid/ready flow control and a one-entry skid buffer.

---
 rtl/id_exe_pkg.sv | 29 ++
 rtl/pipe_skid_buf.sv | 77 +++++++
 rtl/id_exe_pipe_slot.sv | 92 +++++++++
 3 files changed

// File: rtl/id_exe_pkg.sv
// id_exe_pkg: shared definitions for the ID->EXE pipeline slot.
//   - default field widths
//   - bit positions of the side-effect control flags inside the 5-bit ctrl field
//   - width of the flat bundle that the slot carries through its skid buffer
package id_exe_pkg;

    localparam int WORD_W_DEF  = 32;
    localparam int RADDR_W_DEF = 5;
    localparam int CMD_W_DEF   = 4;
    localparam int INSTR_W_DEF = 16;
    localparam int CNT_W_DEF   = 8;

    localparam int CTRL_W = 5;

    // ctrl = {mem_r_en, mem_w_en, wb_en, br_taken, add_base}
    localparam int CTRL_MEM_R    = 4;
    localparam int CTRL_MEM_W    = 3;
    localparam int CTRL_WB       = 2;
    localparam int CTRL_BR       = 1;
    localparam int CTRL_ADD_BASE = 0;

    // Bundle layout, MSB first:
    // {ctrl, cmd, dest, src1, src2, cdest, val1, val2, st_val, pc, instr}
    function automatic int bundle_w(input int word_w, input int raddr_w,
                                    input int cmd_w,  input int instr_w);
        return CTRL_W + cmd_w + 4 * raddr_w + 4 * word_w + instr_w;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry valid/ready register slice on a flat W-bit bundle.
//   The main entry drives the output; the skid entry catches the one bundle
//   that can be accepted in the cycle the consumer stalls. in_ready_o comes
//   straight from a flop (!skid valid), so the upstream sees no combinational
//   path from out_ready_i.
// Ports:
//   clk, rst                 clock / async active-high reset
//   flush_i                  drop both entries at the next edge
//   in_valid_i/in_ready_o    producer handshake, in_data_i bundle
//   out_valid_o/out_ready_i  consumer handshake, out_data_o bundle (main entry)
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         main_vld_q, main_vld_d;
    logic         skid_vld_q, skid_vld_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept, xfer;

    assign in_ready_o  = !skid_vld_q;
    assign out_valid_o = main_vld_q;
    assign out_data_o  = main_q;

    assign accept = in_valid_i & in_ready_o;
    assign xfer   = main_vld_q & out_ready_i;

    // The skid can only be full while main is full and stalled, and while it
    // is full in_ready is low, so accept and a skid drain never coincide.
    always_comb begin
        main_vld_d = main_vld_q;
        main_d     = main_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (flush_i) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || xfer) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = accept;
                if (accept) main_d = in_data_i;
            end
        end else if (accept) begin
            skid_d     = in_data_i;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

endmodule

// File: rtl/id_exe_pipe_slot.sv
// id_exe_pipe_slot: ID->EXE pipeline boundary.
//   Packs the decoded bundle, runs it through a skid buffer, unpacks it for
//   EXE, forces side-effect controls low on bubbles and counts stalled cycles.
// Ports:
//   clk, rst               clock / async active-high reset
//   flush                  kill held bundles (hazard unit)
//   in_valid/in_ready      decode handshake; in_* bundle fields
//   out_valid/out_ready    EXE handshake; out_* registered bundle fields
//   stall_cnt              saturating count of cycles with out_valid & !out_ready
module id_exe_pipe_slot
    import id_exe_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int CMD_W   = CMD_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [CMD_W-1:0]   in_cmd,
    input  logic [RADDR_W-1:0] in_dest,
    input  logic [RADDR_W-1:0] in_src1,
    input  logic [RADDR_W-1:0] in_src2,
    input  logic [RADDR_W-1:0] in_cdest,
    input  logic [WORD_W-1:0]  in_val1,
    input  logic [WORD_W-1:0]  in_val2,
    input  logic [WORD_W-1:0]  in_st_val,
    input  logic [WORD_W-1:0]  in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [CMD_W-1:0]   out_cmd,
    output logic [RADDR_W-1:0] out_dest,
    output logic [RADDR_W-1:0] out_src1,
    output logic [RADDR_W-1:0] out_src2,
    output logic [RADDR_W-1:0] out_cdest,
    output logic [WORD_W-1:0]  out_val1,
    output logic [WORD_W-1:0]  out_val2,
    output logic [WORD_W-1:0]  out_st_val,
    output logic [WORD_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int BW = bundle_w(WORD_W, RADDR_W, CMD_W, INSTR_W);

    logic [BW-1:0]     in_bundle, out_bundle;
    logic [CTRL_W-1:0] held_ctrl;

    assign in_bundle = {in_ctrl, in_cmd, in_dest, in_src1, in_src2, in_cdest,
                        in_val1, in_val2, in_st_val, in_pc, in_instr};

    pipe_skid_buf #(.W(BW)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_bundle),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_bundle)
    );

    assign {held_ctrl, out_cmd, out_dest, out_src1, out_src2, out_cdest,
            out_val1, out_val2, out_st_val, out_pc, out_instr} = out_bundle;

    // A bubble must never write memory, write back or redirect the PC.
    assign out_ctrl = held_ctrl & {CTRL_W{out_valid}};

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule
